pio_fault_capture: RTL and testbench
====================================

// Module: pio_fault_capture
// PURPOSE
//  Parametrised multi-channel fault-input PIO; Avalon-MM slave on the NIOS bus.
//  Generalises the single-bit hull-fault input to WIDTH channels with synchroniser,
//  per-channel debounce, programmable polarity, edge capture and a maskable irq.
//  Sits between board fault lines (hull/motor drivers) and the CPU interrupt controller.
// PARAMETERS
//  WIDTH            8   number of fault channels (1..32)
//  SYNC_STAGES      2   synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  16  consecutive stable cycles before level accepted (>=1)
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   WIDTH  write data
//  in_port     in   WIDTH  raw asynchronous fault lines
//  readdata    out  WIDTH  registered read data
//  irq         out  1      interrupt request, active high
// BEHAVIOUR
//  Reset: clk is the only clock; reset_n is asynchronous, active-low. All flops clear:
//   sync chain, stable, counters, POLARITY, MASK, EDGE, fault_d, readdata=0, irq=0.
//   Assertion mid-debounce or mid-read aborts it; no state survives.
//  Register map (wr = chipselect & ~write_n):
//   0 DATA   RO  debounced fault vector (stable ^ POLARITY); writes ignored
//   1 POLARITY RW bit=1 -> channel fault is active-low
//   2 MASK   RW  irq enable per channel
//   3 EDGE   RW1C captured fault events; writing 1 clears bit, 0 leaves it
//  Read: readdata <= mux(address) every clk edge; 1-cycle latency, no wait states.
//  Sync: SYNC_STAGES flop chain per channel; output = s.
//  Debounce (per channel, counter width $clog2(DEBOUNCE_CYCLES+1)):
//   s==stable -> cnt<=0; s!=stable & cnt==DEBOUNCE_CYCLES-1 -> stable<=s, cnt<=0;
//   else cnt<=cnt+1. Any glitch back to stable restarts count.
//   Pin-to-stable latency = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
//  fault = stable ^ POLARITY; fault_d <= fault each cycle.
//  Edge event: fault & ~fault_d (assertion only, see CONFIGURATION).
//   Suppressed in the cycle following a POLARITY write (no false events).
//  EDGE update: EDGE <= (EDGE & ~clr) | event; set wins over same-cycle clear.
//  irq = |(EDGE & MASK), combinational from flops; masking never clears EDGE.
//  Bits above WIDTH in writedata do not exist; unused readdata bits n/a.
// CONFIGURATION
//  `define PIO_FAULT_BOTH_EDGE_EN:
//   defined   -> event = fault ^ fault_d (assert and deassert both captured).
//   undefined -> event = fault & ~fault_d (assertion only). Default: undefined.
//  POLARITY-write suppression applies in both builds.
// TESTING
//  1 reset, read addr0..3 -> all 0x00, irq=0.
//  2 in_port[0]=1 held; read DATA -> 0x01 only after SYNC_STAGES+16=18 cycles.
//  3 in_port[3] pulse 10 cycles (<16) -> DATA, EDGE stay 0x00; debounce restarts.
//  4 MASK=0x04, in_port[2] high 20 cycles -> EDGE=0x04, irq=1; write EDGE=0x04
//    -> EDGE=0x00, irq=0; clear in same cycle as new event -> EDGE stays 0x04.
//  5 write POLARITY=0x01 with in_port[0]=0 -> DATA=0x01, EDGE unchanged;
//    then in_port[0]=1 debounced -> DATA=0x00, EDGE bit0 set only if BOTH_EDGE_EN.
//  6 assert reset_n=0 mid-debounce (cnt=8) -> all regs 0; release -> full 18-cycle wait.

Source files
------------

// File: rtl/pio_fault_capture.sv
// Multi-channel fault-input PIO: synchroniser, per-channel debounce, polarity, edge capture, maskable irq.
// Optional build macro: PIO_FAULT_BOTH_EDGE_EN captures deassertion events as well as assertion.
module pio_fault_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] polarity;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] fault;
  logic [WIDTH-1:0] fault_d;
  logic [WIDTH-1:0] evt_raw;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_mux;
  logic             pol_wr_d;
  logic             wr;
  logic             wr_pol;
  logic             wr_mask;
  logic             wr_edge;

  assign wr      = chipselect & ~write_n;
  assign wr_pol  = wr && (address == 2'd1);
  assign wr_mask = wr && (address == 2'd2);
  assign wr_edge = wr && (address == 2'd3);

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Any sample matching the accepted level restarts the count.
  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt[g]    <= '0;
        stable[g] <= 1'b0;
      end else if (s[g] == stable[g]) begin
        cnt[g] <= '0;
      end else if (cnt[g] == CNT_MAX) begin
        stable[g] <= s[g];
        cnt[g]    <= '0;
      end else begin
        cnt[g] <= cnt[g] + 1'b1;
      end
    end
  end

  assign fault = stable ^ polarity;

`ifdef PIO_FAULT_BOTH_EDGE_EN
  assign evt_raw = fault ^ fault_d;
`else
  assign evt_raw = fault & ~fault_d;
`endif

  // A polarity flip changes fault without any pin activity; drop that cycle.
  assign evt = pol_wr_d ? '0 : evt_raw;
  assign clr = wr_edge ? writedata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      polarity <= '0;
      mask     <= '0;
      edge_q   <= '0;
      fault_d  <= '0;
      pol_wr_d <= 1'b0;
    end else begin
      if (wr_pol) polarity <= writedata;
      if (wr_mask) mask <= writedata;
      edge_q   <= (edge_q & ~clr) | evt;
      fault_d  <= fault;
      pol_wr_d <= wr_pol;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0: rd_mux = fault;
      2'd1: rd_mux = polarity;
      2'd2: rd_mux = mask;
      2'd3: rd_mux = edge_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_q & mask);

endmodule

// File: tb/tb_pio_fault_capture.sv
// Directed bench for pio_fault_capture (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=16).
module tb_pio_fault_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] in_port;
  logic [7:0] readdata;
  logic       irq;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] rd;

  pio_fault_capture #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    #12;
    check("rst_readdata", readdata, 0);
    check("rst_irq", irq, 0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, 0);
    end

    // bit0 accepted 18 edges after the pin moves, visible one edge later
    address    = 2'd0;
    in_port[0] = 1'b1;
    tick(18);
    check("lat18_data", readdata, 8'h00);
    tick();
    check("lat19_data", readdata, 8'h01);
    in_port[0] = 1'b0;
    tick(25);
    wr_reg(2'd3, 8'hFF);
    rd_reg(2'd3, rd);
    check("edge_cleared", rd, 8'h00);

    // short pulse rejected, debounce restarts on return
    in_port[3] = 1'b1;
    tick(10);
    in_port[3] = 1'b0;
    tick(5);
    in_port[3] = 1'b1;
    address    = 2'd0;
    tick(18);
    check("glitch_data18", readdata, 8'h00);
    tick();
    check("glitch_data19", readdata, 8'h08);
    in_port[3] = 1'b0;
    tick(25);
    wr_reg(2'd3, 8'hFF);
    in_port[3] = 1'b1;
    tick(10);
    in_port[3] = 1'b0;
    tick(30);
    rd_reg(2'd0, rd);
    check("pulse_data", rd, 8'h00);
    rd_reg(2'd3, rd);
    check("pulse_edge", rd, 8'h00);

    // edge capture, irq, W1C, same-cycle set vs clear
    wr_reg(2'd2, 8'h04);
    in_port[2] = 1'b1;
    tick(20);
    rd_reg(2'd3, rd);
    check("edge2_set", rd, 8'h04);
    check("irq_set", irq, 1);
    wr_reg(2'd3, 8'h04);
    rd_reg(2'd3, rd);
    check("edge2_clr", rd, 8'h00);
    check("irq_clr", irq, 0);
    in_port[2] = 1'b0;
    tick(25);
    wr_reg(2'd3, 8'hFF);
    in_port[2] = 1'b1;
    tick(18);
    wr_reg(2'd3, 8'h04);
    rd_reg(2'd3, rd);
    check("set_wins", rd, 8'h04);
    check("set_wins_irq", irq, 1);
    wr_reg(2'd2, 8'h00);
    check("mask_off_irq", irq, 0);
    rd_reg(2'd3, rd);
    check("mask_keeps_edge", rd, 8'h04);
    in_port[2] = 1'b0;
    tick(25);
    wr_reg(2'd3, 8'hFF);

    // polarity flip must not fake an event
    wr_reg(2'd1, 8'h01);
    rd_reg(2'd0, rd);
    check("pol_data", rd, 8'h01);
    rd_reg(2'd3, rd);
    check("pol_no_evt", rd, 8'h00);
    rd_reg(2'd1, rd);
    check("pol_reg", rd, 8'h01);
    in_port[0] = 1'b1;
    tick(25);
    rd_reg(2'd0, rd);
    check("pol_deassert", rd, 8'h00);
    rd_reg(2'd3, rd);
`ifdef PIO_FAULT_BOTH_EDGE_EN
    check("pol_deassert_edge", rd, 8'h01);
`else
    check("pol_deassert_edge", rd, 8'h00);
`endif

    // reset mid-debounce aborts everything
    wr_reg(2'd2, 8'hFF);
    in_port = 8'h20;
    tick(10);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd", readdata, 0);
    check("mid_rst_irq", irq, 0);
    tick(2);
    reset_n = 1'b1;
    rd_reg(2'd1, rd);
    check("post_rst_pol", rd, 8'h00);
    rd_reg(2'd2, rd);
    check("post_rst_mask", rd, 8'h00);
    rd_reg(2'd3, rd);
    check("post_rst_edge", rd, 8'h00);
    address = 2'd0;
    tick(15);
    check("post_rst_d18", readdata, 8'h00);
    tick();
    check("post_rst_d19", readdata, 8'h20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
